term_ctrl: RTL and testbench

// - Terminal controller driving VRAM port A of the video block: accepts bytes from UART RX (valid/ready),

---
 rtl/term_ctrl_pkg.sv | 42 ++++
 rtl/term_ctrl_if.sv | 25 ++
 rtl/term_ctrl_bel_timer.sv | 43 ++++
 rtl/term_ctrl.sv | 177 +++++++++++++++++
 tb/tb_term_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/term_ctrl_pkg.sv
// Shared definitions for the terminal controller: geometry defaults, control
// codes, FSM state encoding and the VRAM port A request record.
package term_ctrl_pkg;

   localparam int         DEF_COLS       = 60;
   localparam int         DEF_ROWS       = 17;
   localparam int         DEF_BEL_CYCLES = 1_200_000;
   localparam logic [7:0] DEF_BLANK      = 8'h20;

   localparam int XW = 6;
   localparam int YW = 5;
   localparam int AW = XW + YW;

   localparam logic [7:0] CHR_BEL = 8'h07;
   localparam logic [7:0] CHR_BS  = 8'h08;
   localparam logic [7:0] CHR_TAB = 8'h09;
   localparam logic [7:0] CHR_LF  = 8'h0A;
   localparam logic [7:0] CHR_FF  = 8'h0C;
   localparam logic [7:0] CHR_CR  = 8'h0D;

   typedef enum logic [2:0] {
      ST_CLR_ALL,
      ST_IDLE,
      ST_WRITE,
      ST_SCR_RD,
      ST_SCR_WR,
      ST_CLR_ROW
   } state_e;

   typedef struct packed {
      logic          ce;
      logic          wre;
      logic [AW-1:0] addr;
      logic [7:0]    din;
   } vram_req_t;

   // Printable ASCII plus the whole upper half (code page glyphs); DEL is not drawn.
   function automatic logic is_glyph(input logic [7:0] b);
      return (b >= 8'h20) && (b != 8'h7F);
   endfunction

endpackage

// File: rtl/term_ctrl_if.sv
// UART byte stream handshake, VRAM port A and visual-bel request of the
// terminal controller, seen from the controller (slave) and its environment.
interface term_ctrl_if;

   logic [7:0]                    i_data;
   logic                          i_valid;
   logic                          o_ready;
   logic [term_ctrl_pkg::AW-1:0]  o_vram_addr;
   logic [7:0]                    o_vram_din;
   logic [7:0]                    i_vram_dout;
   logic                          o_vram_ce;
   logic                          o_vram_wre;
   logic                          o_reversev;

   modport slave (
      input  i_data, i_valid, i_vram_dout,
      output o_ready, o_vram_addr, o_vram_din, o_vram_ce, o_vram_wre, o_reversev
   );

   modport master (
      output i_data, i_valid, i_vram_dout,
      input  o_ready, o_vram_addr, o_vram_din, o_vram_ce, o_vram_wre, o_reversev
   );

endinterface

// File: rtl/term_ctrl_bel_timer.sv
// Visual bel timer: a trigger holds o_active high for BEL_CYCLES clocks;
// a new trigger while active restarts the full interval.
module bel_timer #(
   parameter int BEL_CYCLES = 1_200_000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_trig,
   output logic o_active
);

   localparam int CW = $clog2(BEL_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          act_q, act_d;

   // The flag drops one cycle after the counter hits zero, giving exactly BEL_CYCLES high cycles.
   always_comb begin
      cnt_d = cnt_q;
      act_d = act_q;
      if (i_trig) begin
         cnt_d = CW'(BEL_CYCLES - 1);
         act_d = 1'b1;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end else begin
         act_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q <= '0;
         act_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         act_q <= act_d;
      end
   end

   assign o_active = act_q;

endmodule

// File: rtl/term_ctrl.sv
// Terminal controller: consumes UART bytes, draws glyphs at the cursor,
// executes control codes, and scrolls/clears the cell buffer in VRAM.
module term_ctrl
   import term_ctrl_pkg::*;
#(
   parameter int         COLS       = DEF_COLS,
   parameter int         ROWS       = DEF_ROWS,
   parameter int         BEL_CYCLES = DEF_BEL_CYCLES,
   parameter logic [7:0] BLANK      = DEF_BLANK
) (
   input logic        i_clk,
   input logic        i_rst,
   term_ctrl_if.slave bus
);

   localparam logic [XW-1:0] XMAX = XW'(COLS - 1);
   localparam logic [YW-1:0] YMAX = YW'(ROWS - 1);

   state_e        state_q, state_d;
   logic [XW-1:0] x_q, x_d, c_q, c_d;
   logic [YW-1:0] y_q, y_d, r_q, r_d;
   logic          pend_q, pend_d;
   logic          rd2wr_q, rd2wr_d;
   logic          ready_q, ready_d;
   vram_req_t     req_q, req_d;
   logic          accept, start_scr, bel_trig, bel_act;
   logic [XW:0]   tab_x;

   assign accept = bus.i_valid & ready_q;
   assign tab_x  = {1'b0, x_q | 6'd7} + 7'd1;

   // Registered port: req_d/ready_d describe the bus cycle that follows this edge.
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      r_d       = r_q;
      c_d       = c_q;
      pend_d    = pend_q;
      req_d     = req_q;
      req_d.ce  = 1'b0;
      req_d.wre = 1'b0;
      rd2wr_d   = 1'b0;
      ready_d   = 1'b0;
      start_scr = 1'b0;
      bel_trig  = 1'b0;
      unique case (state_q)
         ST_CLR_ALL: begin
            req_d = '{ce: 1'b1, wre: 1'b1, addr: {r_q, c_q}, din: BLANK};
            if (c_q != XMAX) c_d = c_q + 6'd1;
            else begin
               c_d = '0;
               if (r_q != YMAX) r_d = r_q + 5'd1;
               else begin
                  r_d     = '0;
                  x_d     = '0;
                  y_d     = '0;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_IDLE: if (accept) begin
            if (is_glyph(bus.i_data)) begin
               req_d   = '{ce: 1'b1, wre: 1'b1, addr: {y_q, x_q}, din: bus.i_data};
               state_d = ST_WRITE;
               pend_d  = 1'b0;
               if (x_q != XMAX) x_d = x_q + 6'd1;
               else begin
                  x_d = '0;
                  if (y_q != YMAX) y_d = y_q + 5'd1;
                  else pend_d = 1'b1;
               end
            end else begin
               case (bus.i_data)
                  CHR_CR:  x_d = '0;
                  CHR_BS:  if (x_q != '0) x_d = x_q - 6'd1;
                  CHR_TAB: x_d = (tab_x > {1'b0, XMAX}) ? XMAX : tab_x[XW-1:0];
                  CHR_LF:  if (y_q != YMAX) y_d = y_q + 5'd1; else start_scr = 1'b1;
                  CHR_FF: begin
                     state_d = ST_CLR_ALL;
                     r_d     = '0;
                     c_d     = '0;
                  end
                  CHR_BEL: bel_trig = 1'b1;
                  default: ;
               endcase
            end
         end
         ST_WRITE: if (pend_q) start_scr = 1'b1; else state_d = ST_IDLE;
         ST_SCR_RD: begin
            req_d.ce   = 1'b1;
            req_d.addr = {r_q + 5'd1, c_q};
            state_d    = ST_SCR_WR;
         end
         ST_SCR_WR: begin
            req_d.ce   = 1'b1;
            req_d.wre  = 1'b1;
            req_d.addr = {r_q, c_q};
            rd2wr_d    = 1'b1;
            state_d    = ST_SCR_RD;
            if (c_q != XMAX) c_d = c_q + 6'd1;
            else begin
               c_d = '0;
               if (r_q != YMAX - 5'd1) r_d = r_q + 5'd1;
               else begin
                  r_d     = '0;
                  state_d = ST_CLR_ROW;
               end
            end
         end
         ST_CLR_ROW: begin
            req_d = '{ce: 1'b1, wre: 1'b1, addr: {YMAX, c_q}, din: BLANK};
            if (c_q != XMAX) c_d = c_q + 6'd1;
            else begin
               c_d     = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_CLR_ALL;
      endcase
      // The first scroll read goes out on the deciding edge, saving a cycle.
      if (start_scr) begin
         req_d.ce   = 1'b1;
         req_d.wre  = 1'b0;
         req_d.addr = {5'd1, 6'd0};
         r_d        = '0;
         c_d        = '0;
         state_d    = ST_SCR_WR;
      end
      if (state_d == ST_IDLE && (state_q == ST_IDLE || state_q == ST_WRITE)) begin
         ready_d    = 1'b1;
         req_d.ce   = 1'b0;
         req_d.wre  = 1'b0;
         req_d.addr = {y_d, x_d};
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_CLR_ALL;
         x_q     <= '0;
         y_q     <= '0;
         r_q     <= '0;
         c_q     <= '0;
         pend_q  <= 1'b0;
         rd2wr_q <= 1'b0;
         ready_q <= 1'b0;
         req_q   <= '{ce: 1'b0, wre: 1'b0, addr: '0, din: BLANK};
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         r_q     <= r_d;
         c_q     <= c_d;
         pend_q  <= pend_d;
         rd2wr_q <= rd2wr_d;
         ready_q <= ready_d;
         req_q   <= req_d;
      end
   end

   bel_timer #(.BEL_CYCLES(BEL_CYCLES)) u_bel (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_trig   (bel_trig),
      .o_active (bel_act)
   );

   // Scroll writes forward the read data that port A returns during the write cycle.
   assign bus.o_vram_din  = rd2wr_q ? bus.i_vram_dout : req_q.din;
   assign bus.o_ready     = ready_q;
   assign bus.o_vram_addr = req_q.addr;
   assign bus.o_vram_ce   = req_q.ce;
   assign bus.o_vram_wre  = req_q.wre;
   assign bus.o_reversev  = bel_act;

endmodule

// File: tb/tb_term_ctrl.sv
// Self-checking bench for term_ctrl: VRAM port model, screen/cursor reference
// model, directed cases and randomized byte streams.
module tb_term_ctrl;
   import term_ctrl_pkg::*;

   localparam int         COLS  = 60;
   localparam int         ROWS  = 17;
   localparam int         BEL   = 300;
   localparam logic [7:0] BLANK = 8'h20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   term_ctrl_if bus ();

   term_ctrl #(.COLS(COLS), .ROWS(ROWS), .BEL_CYCLES(BEL), .BLANK(BLANK)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // VRAM port A: synchronous read with one cycle of latency.
   logic [7:0] vram [0:2047];
   logic [7:0] dout_q;
   assign bus.i_vram_dout = dout_q;
   always @(posedge clk) begin
      if (bus.o_vram_ce) begin
         if (bus.o_vram_wre) vram[bus.o_vram_addr] <= bus.o_vram_din;
         else dout_q <= vram[bus.o_vram_addr];
      end
   end

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: screen as a flat 64x32 image, cursor as integers.
   logic [7:0] em [0:2047];
   int cx, cy;

   function automatic int adr(input int y, input int x);
      return y * 64 + x;
   endfunction

   task automatic m_clear();
      for (int y = 0; y < ROWS; y++)
         for (int x = 0; x < COLS; x++) em[adr(y, x)] = BLANK;
      cx = 0;
      cy = 0;
   endtask

   task automatic m_newline();
      if (cy < ROWS - 1) cy++;
      else begin
         for (int y = 0; y < ROWS - 1; y++)
            for (int x = 0; x < COLS; x++) em[adr(y, x)] = em[adr(y + 1, x)];
         for (int x = 0; x < COLS; x++) em[adr(ROWS - 1, x)] = BLANK;
      end
   endtask

   task automatic m_byte(input logic [7:0] b);
      int t;
      if (b >= 8'h20 && b != 8'h7F) begin
         em[adr(cy, cx)] = b;
         cx++;
         if (cx == COLS) begin
            cx = 0;
            m_newline();
         end
      end else begin
         case (b)
            8'h0D: cx = 0;
            8'h08: if (cx > 0) cx--;
            8'h09: begin
               t  = (cx | 7) + 1;
               cx = (t > COLS - 1) ? COLS - 1 : t;
            end
            8'h0A: m_newline();
            8'h0C: m_clear();
            default: ;
         endcase
      end
   endtask

   task automatic chk_screen(input string tag);
      int nd = 0;
      for (int a = 0; a < 2048; a++) if (vram[a] !== em[a]) nd++;
      chk(tag, nd, 0);
   endtask

   task automatic wait_ready(input int lim);
      int n = 0;
      while (!bus.o_ready && n < lim) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.o_ready) chk("ready_timeout", 0, 1);
   endtask

   int unsigned t_acc;

   task automatic send(input logic [7:0] b);
      wait_ready(4000);
      bus.i_data  = b;
      bus.i_valid = 1'b1;
      @(posedge clk); #1;
      t_acc       = cyc;
      bus.i_valid = 1'b0;
   endtask

   task automatic step(input logic [7:0] b);
      send(b);
      m_byte(b);
      wait_ready(4000);
      chk("idle_addr", bus.o_vram_addr, adr(cy, cx));
   endtask

   task automatic clear_run();
      int nw = 0;
      int n  = 0;
      while (!bus.o_ready && n < 3000) begin
         @(posedge clk); #1;
         n++;
         if (bus.o_vram_ce && bus.o_vram_wre) nw++;
      end
      chk("clear_writes", nw, ROWS * COLS);
      chk("clear_ready", bus.o_ready, 1);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_ready", bus.o_ready, 0);
      chk("rst_ce", bus.o_vram_ce, 0);
      chk("rst_wre", bus.o_vram_wre, 0);
      chk("rst_addr", bus.o_vram_addr, 0);
      chk("rst_din", bus.o_vram_din, BLANK);
      chk("rst_rev", bus.o_reversev, 0);
   endtask

   initial begin
      int unsigned t1, t2;
      int n, nb;
      logic [7:0] b;
      int k;

      bus.i_valid = 1'b0;
      bus.i_data  = 8'h00;
      for (int a = 0; a < 2048; a++) begin
         vram[a] <= 8'hEE;
         em[a]    = 8'hEE;
      end
      cx = 0;
      cy = 0;

      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs();
      @(negedge clk) rst = 1'b0;
      clear_run();
      m_clear();
      chk("clr_addr", bus.o_vram_addr, 0);
      chk_screen("clr_screen");

      // Glyph at home position
      send(8'h41);
      chk("A_ce", bus.o_vram_ce, 1);
      chk("A_wre", bus.o_vram_wre, 1);
      chk("A_addr", bus.o_vram_addr, 0);
      chk("A_din", bus.o_vram_din, 8'h41);
      m_byte(8'h41);
      wait_ready(10);
      chk("A_idle_addr", bus.o_vram_addr, 11'h001);

      // Last column of row 3 wraps to the next line
      step(8'h0D);
      for (int i = 0; i < 3; i++) step(8'h0A);
      for (int i = 0; i < 59; i++) step(8'h61);
      send(8'h5A);
      chk("Z_addr", bus.o_vram_addr, 3 * 64 + 59);
      chk("Z_din", bus.o_vram_din, 8'h5A);
      chk("Z_wre", bus.o_vram_wre, 1);
      m_byte(8'h5A);
      wait_ready(10);
      chk("Z_idle_addr", bus.o_vram_addr, 11'h100);
      chk_screen("Z_screen");

      // Scroll with row 1 full of 'B' and cursor at (5,16)
      step(8'h0C);
      step(8'h0A);
      for (int i = 0; i < COLS; i++) step(8'h42);
      for (int i = 0; i < 14; i++) step(8'h0A);
      for (int i = 0; i < 5; i++) step(8'h20);
      send(8'h0A);
      chk("scr_ready_low", bus.o_ready, 0);
      n = 0;
      while (!bus.o_ready && n < 4000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("scr_busy", n, (ROWS - 1) * COLS * 2 + COLS);
      m_byte(8'h0A);
      chk("scr_idle_addr", bus.o_vram_addr, adr(ROWS - 1, 5));
      nb = 0;
      for (int x = 0; x < COLS; x++) if (vram[adr(0, x)] === 8'h42) nb++;
      chk("scr_row0_B", nb, COLS);
      chk_screen("scr_screen");

      // Single bel
      send(8'h07);
      t1 = t_acc;
      chk("bel_rise", bus.o_reversev, 1);
      n = 0;
      while (bus.o_reversev && n < BEL + 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bel_len", cyc - t1, BEL);

      // Bel retriggered while active
      send(8'h07);
      t1 = t_acc;
      repeat (100) @(posedge clk);
      #1;
      send(8'h07);
      t2 = t_acc;
      n = 0;
      while (bus.o_reversev && n < 2 * BEL + 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bel2_len", cyc - t1, (t2 - t1) + BEL);

      // Randomized byte stream
      for (int i = 0; i < 200; i++) begin
         k = $urandom_range(0, 99);
         if (k < 60)      b = 8'($urandom_range(8'h20, 8'h7E));
         else if (k < 70) b = 8'($urandom_range(8'h80, 8'hFF));
         else if (k < 76) b = 8'h0A;
         else if (k < 80) b = 8'h0D;
         else if (k < 84) b = 8'h08;
         else if (k < 88) b = 8'h09;
         else if (k < 89) b = 8'h0C;
         else if (k < 91) b = 8'h07;
         else if (k < 94) b = 8'h7F;
         else             b = 8'($urandom_range(0, 8'h1F));
         step(b);
         chk_screen("rnd_screen");
      end

      // Reset in the middle of a scroll, with the bel active
      step(8'h0C);
      for (int i = 0; i < ROWS - 1; i++) step(8'h0A);
      step(8'h07);
      send(8'h0A);
      repeat (100) @(posedge clk);
      #1;
      chk("pre_rst_rev", bus.o_reversev, 1);
      chk("pre_rst_busy", bus.o_ready, 0);
      @(negedge clk) rst = 1'b1;
      #1;
      chk_reset_outputs();
      @(posedge clk); #1;
      @(negedge clk) rst = 1'b0;
      clear_run();
      m_clear();
      chk("rerst_addr", bus.o_vram_addr, 0);
      chk_screen("rerst_screen");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
